// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor {bout,diff} = a - b - bin built around one 1-bit full-subtractor cell.
// Latency: done pulses on the WIDTH-th clock edge after the accepting edge; back-to-back throughput is one result per WIDTH+1 cycles.
// Backpressure: start is sampled only while busy is low (IDLE or DONE); a start during RUN is ignored and does not disturb the operation.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   operation request, accepted when busy==0
//   a      in   minuend, captured on the accepting edge
//   b      in   subtrahend, captured on the accepting edge
//   bin    in   borrow-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, diff/bout were just updated
//   diff   out  difference of the last completed operation
//   bout   out  borrow-out of the last completed operation

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_sh_q,  a_sh_d;   // minuend, consumed from the LSB
   logic [WIDTH-1:0]  b_sh_q,  b_sh_d;   // subtrahend, consumed from the LSB
   logic [WIDTH-1:0]  res_q,   res_d;    // partial difference, filled from the MSB end
   logic              brw_q,   brw_d;    // running borrow between bit slices
   logic [CW-1:0]     cnt_q,   cnt_d;    // index of the bit being processed
   logic [WIDTH-1:0]  diff_q,  diff_d;
   logic              bout_q,  bout_d;

   logic              cell_x;
   logic              cell_y;
   logic              cell_c;
   logic              cell_d;
   logic              cell_br;
   logic [WIDTH-1:0]  res_next;
   logic              accept;

   // ------------------------------------------------------------------
   // 1-bit full-subtractor cell: x - y - c
   // ------------------------------------------------------------------
   assign cell_x  = a_sh_q[0];
   assign cell_y  = b_sh_q[0];
   assign cell_c  = brw_q;
   assign cell_d  = cell_x ^ cell_y ^ cell_c;
   assign cell_br = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & cell_c);

   // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign res_next = (res_q >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      accept  = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept = start;
         end

         S_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = res_next;
            brw_d  = cell_br;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               // Last bit slice: publish the assembled result in the same edge.
               state_d = S_DONE;
               diff_d  = res_next;
               bout_d  = cell_br;
               cnt_d   = '0;
            end
         end

         S_DONE: begin
            // DONE lasts one cycle; a start here chains straight into RUN.
            accept  = start;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         state_d = S_RUN;
         a_sh_d  = a;
         b_sh_d  = b;
         brw_d   = bin;
         cnt_d   = '0;
         res_d   = '0;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
